ss_iter_div: RTL and testbench

SS_ITER_DIV -- requirements
Module: SS_iter_div

---
 rtl/ss_iter_div.sv | 106 ++++++++++
 tb/tb_ss_iter_div.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/ss_iter_div.sv
// Iterative restoring divider: one quotient bit per clock, with a three-state IDLE/RUN/DONE control.
// Divide-by-zero skips the iteration and reports all-ones quotient with the dividend as remainder.
module ss_iter_div #(
  parameter int DATA_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [DATA_W-1:0] i_dividend,
  input  logic [DATA_W-1:0] i_divisor,
  output logic [DATA_W-1:0] o_quotient,
  output logic [DATA_W-1:0] o_remainder,
  output logic              o_div_by_zero,
  output logic              o_busy,
  output logic              o_done
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [1:0]        state;
  logic [DATA_W-1:0] dvd;
  logic [DATA_W-1:0] dsr;
  logic [DATA_W-1:0] rem;
  logic [DATA_W-1:0] quo;
  logic [CNT_W-1:0]  cnt;

  logic [DATA_W:0]   shifted;
  logic [DATA_W:0]   trial;
  logic [DATA_W-1:0] rem_next;
  logic [DATA_W-1:0] quo_next;

  // One restoring step. When the trial goes negative the shifted value is
  // below the divisor, so it always fits back into DATA_W bits.
  // NOTE: every always_comb output is assigned on every path, so no latch is inferred.
  always_comb begin
    shifted = {rem, dvd[DATA_W-1]};
    trial   = shifted - {1'b0, dsr};
    if (!trial[DATA_W]) begin
      rem_next = trial[DATA_W-1:0];
      quo_next = {quo[DATA_W-2:0], 1'b1};
    end else begin
      rem_next = shifted[DATA_W-1:0];
      quo_next = {quo[DATA_W-2:0], 1'b0};
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= ST_IDLE;
      dvd           <= '0;
      dsr           <= '0;
      rem           <= '0;
      quo           <= '0;
      cnt           <= '0;
      o_quotient    <= '0;
      o_remainder   <= '0;
      o_div_by_zero <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            dvd <= i_dividend;
            dsr <= i_divisor;
            rem <= '0;
            quo <= '0;
            cnt <= CNT_W'(DATA_W);
            if (i_divisor == '0) begin
              state         <= ST_DONE;
              o_quotient    <= '1;
              o_remainder   <= i_dividend;
              o_div_by_zero <= 1'b1;
            end else begin
              state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          rem <= rem_next;
          quo <= quo_next;
          dvd <= {dvd[DATA_W-2:0], 1'b0};
          cnt <= cnt - CNT_W'(1);
          // Last step: publish the step's result directly on the DONE transition.
          if (cnt == CNT_W'(1)) begin
            state         <= ST_DONE;
            o_quotient    <= quo_next;
            o_remainder   <= rem_next;
            o_div_by_zero <= 1'b0;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Decoded from the state register only, so i_start has no path to o_done.
  assign o_busy = (state != ST_IDLE);
  assign o_done = (state == ST_DONE);

endmodule

// File: tb/tb_ss_iter_div.sv
// Self-checking bench for ss_iter_div: directed corner cases, reset abort,
// back-to-back runs and randomized operands against an arithmetic reference.
module tb_ss_iter_div;

  localparam int W = 16;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
  logic         busy;
  logic         done;

  int total = 0;
  int bad   = 0;

  ss_iter_div #(.DATA_W(W)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .i_dividend   (dividend),
    .i_divisor    (divisor),
    .o_quotient   (quotient),
    .o_remainder  (remainder),
    .o_div_by_zero(div_by_zero),
    .o_busy       (busy),
    .o_done       (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got=timeout exp=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Runs one operation starting from a negedge in IDLE; ends on a negedge in IDLE.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] eq, er;
    logic         edbz;
    int           elat, k;
    bit           seen, busy_ok;
    if (b == 0) begin
      eq = '1; er = a; edbz = 1'b1; elat = 1;
    end else begin
      eq = a / b; er = a % b; edbz = 1'b0; elat = W + 1;
    end
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk);
    @(negedge clk);
    // Operands scrambled after acceptance must not disturb the result.
    start = 1'b0; dividend = W'($urandom); divisor = W'($urandom);
    k = 1; seen = 0; busy_ok = 1;
    while (k <= 40 && !seen) begin
      if (done) begin
        seen = 1;
        if (!busy) busy_ok = 0;
      end else begin
        if (!busy) busy_ok = 0;
        start = (b != 0 && (k == 3 || k == 4));
        @(negedge clk);
        k++;
      end
    end
    start = 1'b0;
    check("latency", seen ? 64'(k) : 64'(0), 64'(elat));
    check("busy_run", 64'(busy_ok), 64'(1));
    check("quotient", 64'(quotient), 64'(eq));
    check("remainder", 64'(remainder), 64'(er));
    check("div_by_zero", 64'(div_by_zero), 64'(edbz));
    if (b != 0) begin
      check("reconstruct", 64'(quotient) * 64'(b) + 64'(remainder), 64'(a));
      check("rem_lt_div", 64'(remainder < b), 64'(1));
    end
    @(negedge clk);
    check("idle_after", {62'd0, busy, done}, 64'd0);
  endtask

  initial begin
    logic [W-1:0] a, b;
    logic [W-1:0] bq_a [3];
    logic [W-1:0] bq_b [3];
    int           idx, dcount;
    bit           exp_done;

    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    #7;
    check("reset_q", 64'(quotient), 64'd0);
    check("reset_r", 64'(remainder), 64'd0);
    check("reset_flags", {61'd0, div_by_zero, busy, done}, 64'd0);
    #5 rst_n = 1'b1;
    @(negedge clk);

    // Directed corner cases.
    run_op(16'd100, 16'd7);
    run_op(16'd5, 16'd9);
    run_op(16'hFFFF, 16'd1);
    run_op(16'h1234, 16'd0);
    run_op(16'd0, 16'd3);
    run_op(16'hFFFF, 16'hFFFF);

    // Reset asserted in RUN cycle 8 of 100/7 aborts the operation silently.
    start = 1'b1; dividend = 16'd100; divisor = 16'd7;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    check("pre_abort_busy", 64'(busy), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check("abort_q", 64'(quotient), 64'd0);
    check("abort_r", 64'(remainder), 64'd0);
    check("abort_flags", {61'd0, div_by_zero, busy, done}, 64'd0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    dcount = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done || busy) dcount++;
    end
    check("no_done_after_abort", 64'(dcount), 64'd0);
    check("abort_q_hold", 64'(quotient), 64'd0);
    run_op(16'd200, 16'd7);

    // Back-to-back with i_start held; operands change mid-RUN for the next op.
    bq_a[0] = 16'd1000; bq_b[0] = 16'd3;
    bq_a[1] = 16'd500;  bq_b[1] = 16'd9;
    bq_a[2] = 16'd777;  bq_b[2] = 16'd5;
    idx = 0;
    for (int n = 0; n < 60; n++) begin
      exp_done = (n == 17 || n == 35 || n == 53);
      check($sformatf("b2b_done_%0d", n), 64'(done), 64'(exp_done));
      if (done && idx < 3) begin
        check("b2b_q", 64'(quotient), 64'(bq_a[idx] / bq_b[idx]));
        check("b2b_r", 64'(remainder), 64'(bq_a[idx] % bq_b[idx]));
        idx++;
      end
      if (n == 0)  begin start = 1'b1; dividend = bq_a[0]; divisor = bq_b[0]; end
      if (n == 5)  begin dividend = bq_a[1]; divisor = bq_b[1]; end
      if (n == 25) begin dividend = bq_a[2]; divisor = bq_b[2]; end
      if (n == 40) start = 1'b0;
      @(negedge clk);
    end
    check("b2b_count", 64'(idx), 64'd3);
    check("b2b_idle", {62'd0, busy, done}, 64'd0);

    // Randomized operands, biased toward the boundary divisors.
    for (int i = 0; i < 1200; i++) begin
      a = W'($urandom);
      case ($urandom_range(0, 5))
        0:       b = 16'd1;
        1:       b = a;
        2:       b = 16'd0;
        3:       b = W'($urandom_range(1, 15));
        default: b = W'($urandom);
      endcase
      run_op(a, b);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
